// File: rtl/issue_queue.sv
// Dual-push, dual-pop in-order issue queue between decode and the EX register.
// Presents the two oldest bundles and picks 0/1/2 to issue each cycle.
module issue_queue #(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     stall,
  input  logic                     in_valid1,
  input  logic                     in_valid2,
  input  logic [DATA_W-1:0]        in_data1,
  input  logic [DATA_W-1:0]        in_data2,
  input  logic                     in_solo1,
  input  logic                     in_solo2,
  input  logic [4:0]               in_rd1,
  input  logic [4:0]               in_rd2,
  input  logic                     in_we1,
  input  logic                     in_we2,
  input  logic [4:0]               in_rs1_1,
  input  logic [4:0]               in_rs2_1,
  input  logic [4:0]               in_rs1_2,
  input  logic [4:0]               in_rs2_2,
  output logic                     in_ready,
  output logic                     o_valid1,
  output logic                     o_valid2,
  output logic [DATA_W-1:0]        o_data1,
  output logic [DATA_W-1:0]        o_data2,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic       solo;
    logic [4:0] rd;
    logic       we;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } meta_t;

  logic [DATA_W-1:0] data_q [DEPTH];
  meta_t             meta_q [DEPTH];

  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [CW-1:0] count_q;
  logic [1:0]    push_n;
  logic [1:0]    pop_n;
  meta_t         m0;
  meta_t         m1;
  meta_t         in_m1;
  meta_t         in_m2;
  logic          dep;

  assign head_p1 = head_q + AW'(1);
  assign tail_p1 = tail_q + AW'(1);

  assign in_m1 = '{solo: in_solo1, rd: in_rd1, we: in_we1,
                   rs1: in_rs1_1, rs2: in_rs2_1};
  assign in_m2 = '{solo: in_solo2, rd: in_rd2, we: in_we2,
                   rs1: in_rs1_2, rs2: in_rs2_2};

  assign in_ready = (count_q <= CW'(DEPTH - 2));

  always_comb begin
    push_n = 2'd0;
    if (in_ready && in_valid1 && !flush)
      push_n = in_valid2 ? 2'd2 : 2'd1;
  end

  assign m0      = meta_q[head_q];
  assign m1      = meta_q[head_p1];
  assign o_data1 = data_q[head_q];
  assign o_data2 = data_q[head_p1];

  // RAW between the two head entries; x0 never creates a hazard
  assign dep = m0.we && (m0.rd != 5'd0) &&
               ((m0.rd == m1.rs1) || (m0.rd == m1.rs2));

  assign o_valid1 = (count_q != '0) && !flush && !stall;
  assign o_valid2 = (count_q >= CW'(2)) && !m0.solo && !m1.solo &&
                    !dep && !flush && !stall;

  assign pop_n   = {1'b0, o_valid1} + {1'b0, o_valid2};
  assign o_count = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + AW'(pop_n);
      tail_q  <= tail_q + AW'(push_n);
      count_q <= count_q + CW'(push_n) - CW'(pop_n);
    end
  end

  // Payload storage needs no reset; entries are only read once pushed
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      data_q[tail_q] <= in_data1;
      meta_q[tail_q] <= in_m1;
    end
    if (push_n == 2'd2) begin
      data_q[tail_p1] <= in_data2;
      meta_q[tail_p1] <= in_m2;
    end
  end

endmodule
